// File: rtl/img_filter_pkg.sv
// Shared types and constants for the pixel filter pipeline: mode encoding,
// pipeline latency, default luma weights and the sync sideband bundle.
package img_filter_pkg;
  typedef enum logic [1:0] {FM_PASS, FM_GRAY, FM_THRESH, FM_INVERT} filter_mode_e;

  localparam int PIPE_LAT = 3;

  localparam int DEF_COEF_R = 77;
  localparam int DEF_COEF_G = 150;
  localparam int DEF_COEF_B = 29;

  localparam logic [7:0] THR_RST = 8'h80;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;
endpackage

// File: rtl/img_luma_calc.sv
// Stages 1-2: expand channels to 8 bits, weight them, sum to 8-bit luma.
// Carries the raw pixel and sync bits alongside so they stay aligned.
module img_luma_calc
  import img_filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int COEF_R = DEF_COEF_R,
  parameter int COEF_G = DEF_COEF_G,
  parameter int COEF_B = DEF_COEF_B,
  parameter bit VS_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  sync_t             i_sync,
  input  logic [3*CH_W-1:0] i_rgb,
  output sync_t             o_sync,
  output logic [3*CH_W-1:0] o_rgb,
  output logic [7:0]        o_gray
);
  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: ~VS_POL};

  logic [CH_W-1:0] w_r, w_g, w_b;
  logic [7:0]      w_r8, w_g8, w_b8;
  logic [15:0]     w_pr, w_pg, w_pb;
  logic [7:0]      w_gray;

  sync_t             r_sync_pipe [2:1];
  logic [3*CH_W-1:0] r_rgb_pipe  [2:1];
  logic [15:0]       r_pr, r_pg, r_pb;
  logic [7:0]        r_gray;

  assign w_r = i_rgb[3*CH_W-1 -: CH_W];
  assign w_g = i_rgb[2*CH_W-1 -: CH_W];
  assign w_b = i_rgb[CH_W-1   -: CH_W];

  // MSB replication: keep the top 8 bits of {c,c} so full-scale maps to 0xFF
  assign w_r8 = 8'({w_r, w_r} >> (2*CH_W-8));
  assign w_g8 = 8'({w_g, w_g} >> (2*CH_W-8));
  assign w_b8 = 8'({w_b, w_b} >> (2*CH_W-8));

  assign w_pr = 16'(w_r8) * 16'(COEF_R);
  assign w_pg = 16'(w_g8) * 16'(COEF_G);
  assign w_pb = 16'(w_b8) * 16'(COEF_B);

  // Weights total 256, so the 16-bit sum cannot wrap; luma is its upper byte
  assign w_gray = 8'((r_pr + r_pg + r_pb) >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_pipe[1] <= SYNC_IDLE;
      r_sync_pipe[2] <= SYNC_IDLE;
      r_rgb_pipe[1]  <= '0;
      r_rgb_pipe[2]  <= '0;
      r_pr           <= '0;
      r_pg           <= '0;
      r_pb           <= '0;
      r_gray         <= '0;
    end else begin
      r_sync_pipe[1] <= i_sync;
      r_rgb_pipe[1]  <= i_rgb;
      r_pr           <= w_pr;
      r_pg           <= w_pg;
      r_pb           <= w_pb;
      r_sync_pipe[2] <= r_sync_pipe[1];
      r_rgb_pipe[2]  <= r_rgb_pipe[1];
      r_gray         <= w_gray;
    end
  end

  assign o_sync = r_sync_pipe[2];
  assign o_rgb  = r_rgb_pipe[2];
  assign o_gray = r_gray;
endmodule

// File: rtl/img_color_filter_pipe.sv
// 3-cycle pixel filter (pass/gray/threshold/invert), mode latched per frame.
// Define IMG_LUMA_STATS_EN to add the per-frame luma accumulator outputs.
module img_color_filter_pipe
  import img_filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int COEF_R = DEF_COEF_R,
  parameter int COEF_G = DEF_COEF_G,
  parameter int COEF_B = DEF_COEF_B,
  parameter bit VS_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DE,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [3*CH_W-1:0] rgb_in,
  input  logic [1:0]        mode,
  input  logic [7:0]        thr,
  output logic              DE_out,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic [3*CH_W-1:0] rgb_out,
  output logic [1:0]        mode_active
`ifdef IMG_LUMA_STATS_EN
  ,
  output logic [31:0]       frame_luma_sum,
  output logic              stats_valid
`endif
);
  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: ~VS_POL};

  if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_chk
    $error("img_color_filter_pipe: COEF_R+COEF_G+COEF_B must equal 256");
  end
  if (CH_W < 4 || CH_W > 8) begin : g_chw_chk
    $error("img_color_filter_pipe: CH_W must be in 4..8");
  end

  sync_t             w_sync_in, w_sync2;
  logic [3*CH_W-1:0] w_raw, w_pix;
  logic [7:0]        w_gray;
  logic              w_frame_edge;

  logic              r_vs_hist;
  filter_mode_e      r_mode_active;
  logic [7:0]        r_thr_q;
  filter_mode_e      r_mode_pipe [2:1];
  logic [7:0]        r_thr_pipe  [2:1];
  sync_t             r_sync_out;
  logic [3*CH_W-1:0] r_rgb_out;

  assign w_sync_in    = '{de: DE, hs: h_sync_in, vs: v_sync_in};
  assign w_frame_edge = (v_sync_in == VS_POL) && (r_vs_hist != VS_POL);

  img_luma_calc #(
    .CH_W(CH_W), .COEF_R(COEF_R), .COEF_G(COEF_G), .COEF_B(COEF_B), .VS_POL(VS_POL)
  ) u_luma (
    .clk    (clk),
    .rst    (reset),
    .i_sync (w_sync_in),
    .i_rgb  (rgb_in),
    .o_sync (w_sync2),
    .o_rgb  (w_raw),
    .o_gray (w_gray)
  );

  always_comb begin
    w_pix = w_raw;
    case (r_mode_pipe[2])
      FM_GRAY:   w_pix = {3{w_gray[7 -: CH_W]}};
      FM_THRESH: w_pix = (w_gray >= r_thr_pipe[2]) ? '1 : '0;
      FM_INVERT: w_pix = ~w_raw;
      default:   w_pix = w_raw;
    endcase
    if (!w_sync2.de) w_pix = '0;
  end

  // Mode/threshold ride the pipe with each pixel, so a frame edge takes
  // effect starting with the first pixel captured after that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_hist      <= ~VS_POL;
      r_mode_active  <= FM_PASS;
      r_thr_q        <= THR_RST;
      r_mode_pipe[1] <= FM_PASS;
      r_mode_pipe[2] <= FM_PASS;
      r_thr_pipe[1]  <= THR_RST;
      r_thr_pipe[2]  <= THR_RST;
      r_sync_out     <= SYNC_IDLE;
      r_rgb_out      <= '0;
    end else begin
      r_vs_hist <= v_sync_in;
      if (w_frame_edge) begin
        r_mode_active <= filter_mode_e'(mode);
        r_thr_q       <= thr;
      end
      r_mode_pipe[1] <= r_mode_active;
      r_mode_pipe[2] <= r_mode_pipe[1];
      r_thr_pipe[1]  <= r_thr_q;
      r_thr_pipe[2]  <= r_thr_pipe[1];
      r_sync_out     <= w_sync2;
      r_rgb_out      <= w_pix;
    end
  end

  assign DE_out      = r_sync_out.de;
  assign h_sync_out  = r_sync_out.hs;
  assign v_sync_out  = r_sync_out.vs;
  assign rgb_out     = r_rgb_out;
  assign mode_active = r_mode_active;

`ifdef IMG_LUMA_STATS_EN
  logic [31:0] r_acc, r_frame_sum;
  logic        r_stats_valid;
  logic [32:0] w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {25'd0, w_gray};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc         <= '0;
      r_frame_sum   <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      r_stats_valid <= w_frame_edge;
      if (w_frame_edge) begin
        r_frame_sum <= r_acc;
        r_acc       <= '0;
      end else if (w_sync2.de) begin
        r_acc <= w_acc_sum[32] ? 32'hFFFF_FFFF : w_acc_sum[31:0];
      end
    end
  end

  assign frame_luma_sum = r_frame_sum;
  assign stats_valid    = r_stats_valid;
`endif
endmodule
